ppu_pixel_mux: RTL and testbench
================================

# ppu_pixel_mux

Final per-dot pixel stage of the PPU. Sits directly downstream of the background fetch/shift unit and the sprite unit. Each dot it:
- takes the 4-bit background palette address and the 4-bit sprite palette address;
- resolves priority, left-column clipping and the sprite-0 hit;
- looks the winner up in the internal 32-entry palette RAM;
- emits a 6-bit NES system colour to the video encoder.

It also owns the CPU-side palette port used by $2007 accesses to $3F00–$3FFF.

## Interface
Parameters: none.
- clk  in  1  PPU dot clock.
- reset  in  1  synchronous, active-low reset.
- x_idx  in  10  current dot; visible for 0–255.
- scanline  in  10  0 = pre-render line; 1–240 visible (pixel row = scanline−1).
- bg_pixel  in  4  {attr[1:0], pattern[1:0]} from the background unit, valid in the same cycle as x_idx.
- sp_pixel  in  4  sprite palette address, same cycle.
- sp_priority  in  1  1 = sprite behind background.
- sp_zero  in  1  sp_pixel comes from OAM sprite 0.
- show_bg, show_sp  in  1 each  PPUMASK bits 3 and 4.
- show_bg_left, show_sp_left  in  1 each  PPUMASK bits 1 and 2.
- pal_we  in  1  CPU palette write strobe.
- pal_addr  in  5  CPU palette address (VRAM addr[4:0]).
- pal_wdata  in  6  CPU write data (bits 5:0).
- pal_rdata  out  6  CPU read data; 1-cycle latency.
- color_out  out  6  system colour index.
- color_valid  out  1  color_out is a visible pixel.
- out_x, out_y  out  8 each  coordinates of color_out.
- sprite0_hit  out  1  sticky PPUSTATUS bit 6.

## Operation
- **Visible:** scanline ∈ [1,240] and x_idx < 256. Outside this window, stage-1 valid = 0.
- **Opacity:**
  - bg_op = bg_pixel[1:0] ≠ 0.
  - sp_op = sp_pixel[1:0] ≠ 0.
- **Masking (applied before opacity):**
  - bg treated transparent if !show_bg, or (x_idx < 8 and !show_bg_left).
  - sp treated transparent if !show_sp, or (x_idx < 8 and !show_sp_left).
- **Priority → 5-bit palette address:**
  - neither opaque → 5'h00 (backdrop);
  - sp only → {1, sp_pixel};
  - bg only → {0, bg_pixel};
  - both opaque → sp_priority ? {0, bg_pixel} : {1, sp_pixel}.
- **Palette mirroring:** any address with [1:0] = 0 and [4] = 1 (0x10/14/18/1C) maps to [4] = 0. Applies to both the render and CPU ports.
- **Palette RAM:** 32×6 registers, one write port (CPU) and two read ports.
  - CPU write and render read of the same entry in the same cycle: the render port returns the old value.
  - CPU read returns the old value when a write to the same entry occurs in the same cycle.
- **Sprite-0 hit:** set when all of the following hold:
  - visible;
  - bg_op and sp_op (after masking);
  - sp_zero;
  - x_idx ≠ 255.
- sprite0_hit ignores sp_priority.
- sprite0_hit clears at scanline 0, x_idx 1. Clearing wins over a simultaneous set, which cannot occur because scanline 0 is not visible.
- Otherwise sprite0_hit holds its value.

## Timing
- Reset (reset = 0 at a clk edge):
  - color_out, pal_rdata, out_x, out_y = 0.
  - color_valid = 0, sprite0_hit = 0.
  - Pipeline valids = 0.
  - All palette entries = 6'h00.
- Stage 1 (edge N): registers the palette address, valid, x = x_idx[7:0] and y = scanline−1.
- Stage 2 (edge N+1): registers the palette lookup into color_out, color_valid, out_x and out_y.
- Latency from inputs to color_out is 2 clocks.
- sprite0_hit updates at edge N, so it is visible 1 clock after the qualifying dot.
- pal_rdata = palette[mirror(pal_addr)], registered every cycle whether or not a read is requested.
- Reset asserted mid-line: pipeline flushes, and color_valid drops on the next edge. No partial pixel emerges after reset releases; the first valid output is the 2nd edge after the first visible dot.
- Palette changes made mid-frame take effect for dots whose stage-1 edge is after the write edge.

## Configuration
- `PPU_GRAYSCALE_EN` defined:
  - adds input port `grayscale` (1 bit, PPUMASK bit 0), sampled in stage 1 and pipelined with the pixel;
  - when that bit is set, color_out = lookup & 6'h30;
  - pal_rdata is never masked.
- Not defined: the port is absent and colours pass through unmodified.

## Test plan
- **Reset / palette init:** hold reset = 0 for 3 clocks, release → color_out = 0, sprite0_hit = 0. Write 0x3F00 = 6'h0F, read back → pal_rdata = 6'h0F 1 clock later.
- **Mirroring:** write pal_addr 5'h10 = 6'h21 → reading 5'h00 returns 6'h21. A frame with all pixels transparent → every color_out = 6'h21.
- **Priority:** palette[0x05] = 6'h16, palette[0x11] = 6'h2A.
  - bg = 4'h5, sp = 4'h1, sp_priority = 0 → 6'h2A;
  - same with sp_priority = 1 → 6'h16;
  - sp = 4'h0 → 6'h16.
  - Each result appears 2 clocks after the dot, with out_x = x_idx.
- **Left clip:** show_bg_left = 0, bg = 4'h5 at x_idx 0–7 → backdrop colour. At x_idx 8 → 6'h16.
- **Sprite-0 hit:**
  - bg = 4'h1, sp = 4'h2, sp_zero = 1 at scanline 31, x = 100 → sprite0_hit = 1 one clock later;
  - it stays 1 through scanline 261;
  - it clears after scanline 0, x = 1;
  - the same stimulus at x = 255, or at x = 3 with show_sp_left = 0, never sets it.
- **Collision/reset:** CPU write to 5'h05 in the same cycle as a render read of 5'h05 → the old colour is output. Assert reset at x = 128 → color_valid = 0 next edge.

Source files
------------

// File: rtl/ppu_pixel_mux_if.sv
// CPU-side palette port of the PPU pixel mux ($2007 accesses to $3F00-$3FFF).
// The master drives the write strobe, address and data; the slave returns the registered read data.
interface ppu_pixel_mux_if;
    logic       pal_we;
    logic [4:0] pal_addr;
    logic [5:0] pal_wdata;
    logic [5:0] pal_rdata;

    modport master (output pal_we, output pal_addr, output pal_wdata, input pal_rdata);
    modport slave  (input pal_we, input pal_addr, input pal_wdata, output pal_rdata);
endinterface

// File: rtl/ppu_pixel_mux.sv
// Final PPU dot stage: bg/sprite priority, left clip, sprite-0 hit, palette lookup.
// Optional macro PPU_GRAYSCALE_EN adds a grayscale input that masks rendered colours to 6'h30.
module ppu_pixel_mux (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x_idx,
    input  logic [9:0]  scanline,
    input  logic [3:0]  bg_pixel,
    input  logic [3:0]  sp_pixel,
    input  logic        sp_priority,
    input  logic        sp_zero,
    input  logic        show_bg,
    input  logic        show_sp,
    input  logic        show_bg_left,
    input  logic        show_sp_left,
`ifdef PPU_GRAYSCALE_EN
    input  logic        grayscale,
`endif
    ppu_pixel_mux_if.slave pal,
    output logic [5:0]  color_out,
    output logic        color_valid,
    output logic [7:0]  out_x,
    output logic [7:0]  out_y,
    output logic        sprite0_hit
);

    // Sprite backdrop entries 0x10/14/18/1C alias the background ones.
    function automatic logic [4:0] pal_mirror(input logic [4:0] a);
        return (a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
    endfunction

    logic [5:0] palette [32];
    logic [4:0] wr_addr;

    assign wr_addr = pal_mirror(pal.pal_addr);

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_entry
            logic [5:0] entry_reg;
            always_ff @(posedge clk) begin
                if (!reset) begin
                    entry_reg <= 6'h00;
                end else if (pal.pal_we && (wr_addr == 5'(gi))) begin
                    entry_reg <= pal.pal_wdata;
                end
            end
            assign palette[gi] = entry_reg;
        end
    endgenerate

    // Stage-1 combinational decode
    logic       visible;
    logic       bg_op;
    logic       sp_op;
    logic       left_col;
    logic [4:0] pix_addr_next;
    logic [7:0] y_next;
    logic [9:0] y_full;

    assign visible  = (scanline >= 10'd1) && (scanline <= 10'd240) && (x_idx < 10'd256);
    assign left_col = (x_idx < 10'd8);
    assign bg_op    = show_bg && !(left_col && !show_bg_left) && (bg_pixel[1:0] != 2'b00);
    assign sp_op    = show_sp && !(left_col && !show_sp_left) && (sp_pixel[1:0] != 2'b00);
    assign y_full   = scanline - 10'd1;
    assign y_next   = y_full[7:0];

    always_comb begin
        pix_addr_next = 5'h00;
        if (sp_op && (!bg_op || !sp_priority)) begin
            pix_addr_next = {1'b1, sp_pixel};
        end else if (bg_op) begin
            pix_addr_next = {1'b0, bg_pixel};
        end
        pix_addr_next = pal_mirror(pix_addr_next);
    end

    logic [4:0] addr_reg;
    logic       valid_reg;
    logic [7:0] x_reg;
    logic [7:0] y_reg;
    logic       gray_reg;
    logic       gray_next;

`ifdef PPU_GRAYSCALE_EN
    assign gray_next = grayscale;
`else
    assign gray_next = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_reg  <= 5'h00;
            valid_reg <= 1'b0;
            x_reg     <= 8'h00;
            y_reg     <= 8'h00;
            gray_reg  <= 1'b0;
        end else begin
            addr_reg  <= pix_addr_next;
            valid_reg <= visible;
            x_reg     <= x_idx[7:0];
            y_reg     <= y_next;
            gray_reg  <= gray_next;
        end
    end

    // Sticky hit; the clear dot lies on a non-visible line so it never races a set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sprite0_hit <= 1'b0;
        end else if ((scanline == 10'd0) && (x_idx == 10'd1)) begin
            sprite0_hit <= 1'b0;
        end else if (visible && bg_op && sp_op && sp_zero && (x_idx != 10'd255)) begin
            sprite0_hit <= 1'b1;
        end
    end

    logic [5:0] lookup;
    logic [5:0] color_next;

    assign lookup     = palette[addr_reg];
    assign color_next = gray_reg ? (lookup & 6'h30) : lookup;

    always_ff @(posedge clk) begin
        if (!reset) begin
            color_out     <= 6'h00;
            color_valid   <= 1'b0;
            out_x         <= 8'h00;
            out_y         <= 8'h00;
            pal.pal_rdata <= 6'h00;
        end else begin
            color_out     <= color_next;
            color_valid   <= valid_reg;
            out_x         <= x_reg;
            out_y         <= y_reg;
            pal.pal_rdata <= palette[wr_addr];
        end
    end

endmodule

// File: tb/tb_ppu_pixel_mux.sv
// Directed self-checking bench for ppu_pixel_mux: palette port, priority, clip, sprite-0 hit, reset.
module tb_ppu_pixel_mux;
    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x_idx;
    logic [9:0] scanline;
    logic [3:0] bg_pixel;
    logic [3:0] sp_pixel;
    logic       sp_priority;
    logic       sp_zero;
    logic       show_bg;
    logic       show_sp;
    logic       show_bg_left;
    logic       show_sp_left;
`ifdef PPU_GRAYSCALE_EN
    logic       grayscale = 1'b0;
`endif
    logic [5:0] color_out;
    logic       color_valid;
    logic [7:0] out_x;
    logic [7:0] out_y;
    logic       sprite0_hit;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    ppu_pixel_mux_if pal_if ();

    ppu_pixel_mux dut (
        .clk          (clk),
        .reset        (reset),
        .x_idx        (x_idx),
        .scanline     (scanline),
        .bg_pixel     (bg_pixel),
        .sp_pixel     (sp_pixel),
        .sp_priority  (sp_priority),
        .sp_zero      (sp_zero),
        .show_bg      (show_bg),
        .show_sp      (show_sp),
        .show_bg_left (show_bg_left),
        .show_sp_left (show_sp_left),
`ifdef PPU_GRAYSCALE_EN
        .grayscale    (grayscale),
`endif
        .pal          (pal_if.slave),
        .color_out    (color_out),
        .color_valid  (color_valid),
        .out_x        (out_x),
        .out_y        (out_y),
        .sprite0_hit  (sprite0_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        x_idx       = 10'd0;
        scanline    = 10'd250;
        bg_pixel    = 4'h0;
        sp_pixel    = 4'h0;
        sp_priority = 1'b0;
        sp_zero     = 1'b0;
    endtask

    task automatic pal_write(input logic [4:0] a, input logic [5:0] d);
        pal_if.pal_addr  = a;
        pal_if.pal_wdata = d;
        pal_if.pal_we    = 1'b1;
        tick();
        pal_if.pal_we    = 1'b0;
    endtask

    task automatic pal_read(input string tag, input logic [4:0] a, input logic [5:0] exp);
        pal_if.pal_addr = a;
        tick();
        check(tag, 32'(pal_if.pal_rdata), 32'(exp));
    endtask

    task automatic set_dot(input logic [9:0] sl, input logic [9:0] x, input logic [3:0] bg,
                           input logic [3:0] sp, input logic pri, input logic zero);
        scanline    = sl;
        x_idx       = x;
        bg_pixel    = bg;
        sp_pixel    = sp;
        sp_priority = pri;
        sp_zero     = zero;
    endtask

    // One visible dot, then an idle dot; result checked 2 edges after the dot.
    task automatic dot_check(input string tag, input logic [9:0] sl, input logic [9:0] x,
                             input logic [3:0] bg, input logic [3:0] sp, input logic pri,
                             input logic [5:0] exp_color);
        set_dot(sl, x, bg, sp, pri, 1'b0);
        tick();
        idle_inputs();
        tick();
        check({tag, "_color"}, 32'(color_out), 32'(exp_color));
        check({tag, "_valid"}, 32'(color_valid), 32'd1);
        check({tag, "_x"}, 32'(out_x), 32'(x[7:0]));
        check({tag, "_y"}, 32'(out_y), 32'(sl - 10'd1) & 32'hFF);
    endtask

    initial begin
        reset            = 1'b0;
        pal_if.pal_we    = 1'b0;
        pal_if.pal_addr  = 5'h00;
        pal_if.pal_wdata = 6'h00;
        show_bg          = 1'b1;
        show_sp          = 1'b1;
        show_bg_left     = 1'b1;
        show_sp_left     = 1'b1;
        idle_inputs();
        repeat (3) tick();
        check("rst_color", 32'(color_out), 32'h0);
        check("rst_valid", 32'(color_valid), 32'h0);
        check("rst_hit", 32'(sprite0_hit), 32'h0);
        check("rst_rdata", 32'(pal_if.pal_rdata), 32'h0);
        check("rst_outx", 32'(out_x), 32'h0);
        reset = 1'b1;
        tick();

        // Palette port: write/read collision returns old value, next read returns new
        pal_write(5'h00, 6'h0F);
        check("pal_wr_rd_old", 32'(pal_if.pal_rdata), 32'h00);
        pal_read("pal_00", 5'h00, 6'h0F);

        pal_write(5'h10, 6'h21);
        pal_read("mirror_00", 5'h00, 6'h21);
        pal_read("mirror_10", 5'h10, 6'h21);

        for (int i = 0; i < 4; i++)
            dot_check($sformatf("transp%0d", i), 10'd1 + 10'(i * 60), 10'(i * 80), 4'h0, 4'h0, 1'b0, 6'h21);

        // Non-visible dot yields no valid pixel
        set_dot(10'd241, 10'd10, 4'h5, 4'h0, 1'b0, 1'b0);
        tick();
        idle_inputs();
        tick();
        check("invis_valid", 32'(color_valid), 32'h0);

        pal_write(5'h05, 6'h16);
        pal_write(5'h11, 6'h2A);
        dot_check("pri_sp_front", 10'd5, 10'd20, 4'h5, 4'h1, 1'b0, 6'h2A);
        dot_check("pri_sp_behind", 10'd5, 10'd21, 4'h5, 4'h1, 1'b1, 6'h16);
        dot_check("pri_bg_only", 10'd5, 10'd22, 4'h5, 4'h0, 1'b0, 6'h16);
        dot_check("pri_sp_only", 10'd5, 10'd23, 4'h0, 4'h1, 1'b1, 6'h2A);

        show_bg_left = 1'b0;
        for (int i = 0; i < 8; i++)
            dot_check($sformatf("clip_x%0d", i), 10'd9, 10'(i), 4'h5, 4'h0, 1'b0, 6'h21);
        dot_check("clip_x8", 10'd9, 10'd8, 4'h5, 4'h0, 1'b0, 6'h16);
        show_bg_left = 1'b1;

        // Sprite-0 hit: non-qualifying cases first
        check("hit_pre", 32'(sprite0_hit), 32'h0);
        set_dot(10'd31, 10'd255, 4'h1, 4'h2, 1'b0, 1'b1);
        tick();
        check("hit_x255", 32'(sprite0_hit), 32'h0);
        show_sp_left = 1'b0;
        set_dot(10'd31, 10'd3, 4'h1, 4'h2, 1'b0, 1'b1);
        tick();
        check("hit_clip", 32'(sprite0_hit), 32'h0);
        show_sp_left = 1'b1;
        set_dot(10'd31, 10'd100, 4'h1, 4'h2, 1'b0, 1'b0);
        tick();
        check("hit_not_zero", 32'(sprite0_hit), 32'h0);
        set_dot(10'd31, 10'd100, 4'h1, 4'h2, 1'b1, 1'b1);
        tick();
        check("hit_set", 32'(sprite0_hit), 32'h1);
        idle_inputs();
        set_dot(10'd261, 10'd5, 4'h0, 4'h0, 1'b0, 1'b0);
        tick();
        check("hit_hold261", 32'(sprite0_hit), 32'h1);
        set_dot(10'd0, 10'd0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick();
        check("hit_hold_x0", 32'(sprite0_hit), 32'h1);
        set_dot(10'd0, 10'd1, 4'h0, 4'h0, 1'b0, 1'b0);
        tick();
        check("hit_clear", 32'(sprite0_hit), 32'h0);
        idle_inputs();

        // Render read of 0x05 on the same edge as a CPU write to 0x05
        set_dot(10'd10, 10'd50, 4'h5, 4'h0, 1'b0, 1'b0);
        tick();
        idle_inputs();
        pal_write(5'h05, 6'h3C);
        check("coll_old", 32'(color_out), 32'h16);
        dot_check("coll_new", 10'd10, 10'd51, 4'h5, 4'h0, 1'b0, 6'h3C);

        // Reset mid-line flushes the pipeline and clears the palette
        set_dot(10'd20, 10'd128, 4'h5, 4'h0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check("midrst_valid", 32'(color_valid), 32'h0);
        reset = 1'b1;
        idle_inputs();
        tick();
        check("post_rst_valid", 32'(color_valid), 32'h0);
        pal_read("post_rst_pal05", 5'h05, 6'h00);
        dot_check("post_rst_dot", 10'd20, 10'd129, 4'h5, 4'h0, 1'b0, 6'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
